// File: rtl/display_mux_3dig_pkg.sv
// Shared segment patterns and scan-state encoding for the three-digit display mux.
package display_mux_3dig_pkg;

  // Segment patterns, bit6..0 = a..g, active-high.
  localparam logic [6:0] ZERO    = 7'b1111110;
  localparam logic [6:0] UM      = 7'b0110000;
  localparam logic [6:0] DOIS    = 7'b1101101;
  localparam logic [6:0] TRES    = 7'b1111001;
  localparam logic [6:0] QUATRO  = 7'b0110011;
  localparam logic [6:0] CINCO   = 7'b1011011;
  localparam logic [6:0] SEIS    = 7'b0011111;
  localparam logic [6:0] SETE    = 7'b1110000;
  localparam logic [6:0] OITO    = 7'b1111111;
  localparam logic [6:0] NOVE    = 7'b1110011;
  localparam logic [6:0] APAGADO = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    D1   = 2'd1,
    D2   = 2'd2,
    D3   = 2'd3
  } state_t;

  // Digit enable for a scan state; IDLE enables nothing.
  function automatic logic [2:0] digit_onehot(input state_t s);
    logic [2:0] oh;
    oh = '0;
    case (s)
      D1:      oh = 3'b001;
      D2:      oh = 3'b010;
      D3:      oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/display_mux_3dig_if.sv
// Digit-pattern inputs and multiplexed display outputs of the three-digit mux.
interface display_mux_3dig_if;

  logic       enable;
  logic [6:0] display1;
  logic [6:0] display2;
  logic [6:0] display3;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_start;

  // Upstream decoder / board side.
  modport master (
    output enable, display1, display2, display3,
    input  seg, an, frame_start
  );

  // Display mux side.
  modport slave (
    input  enable, display1, display2, display3,
    output seg, an, frame_start
  );

endinterface

// File: rtl/display_mux_3dig_scan_tick.sv
// Slot counter: counts 0..REFRESH_DIV-1 and flags the last cycle of each slot.
module display_mux_3dig_scan_tick #(
  parameter int unsigned REFRESH_DIV = 50000,
  localparam int unsigned W = $clog2(REFRESH_DIV)
) (
  input  logic         clock,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         last
);

  localparam logic [W-1:0] LAST_COUNT = W'(REFRESH_DIV - 1);

  assign last = (count == LAST_COUNT);

  // Free-running slot counter that wraps after the last cycle; clear holds it at zero.
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (last) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/display_mux_3dig.sv
// Time-multiplexes three 7-segment patterns onto one segment bus with
// frame-atomic capture, leading-zero blanking and a per-slot guard interval.
module display_mux_3dig
  import display_mux_3dig_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 2,
  parameter bit          BLANK_ZEROS = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  display_mux_3dig_if.slave  bus
);

  localparam int unsigned W = $clog2(REFRESH_DIV);

  state_t         state;
  logic [W-1:0]   count;
  logic           last;
  logic           tick_clear;
  logic [6:0]     sh1;
  logic [6:0]     sh2;
  logic [6:0]     sh3;
  logic           in_guard;
  logic           blank3;
  logic           blank2;
  logic [6:0]     seg_d;
  logic [2:0]     an_d;
  logic           frame_start_d;

  // Counter is held at zero whenever the scan is not running, so entering D1
  // from IDLE always starts on count 0 without a separate load path.
  assign tick_clear = reset || !bus.enable || (state == IDLE);

  display_mux_3dig_scan_tick #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan_tick (
    .clock(clock),
    .clear(tick_clear),
    .count(count),
    .last (last)
  );

  // Scan FSM and shadow capture; shadows load only on frame entry and frame wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sh1   <= '0;
      sh2   <= '0;
      sh3   <= '0;
    end else if (!bus.enable) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          state <= D1;
          sh1   <= bus.display1;
          sh2   <= bus.display2;
          sh3   <= bus.display3;
        end
        D1: if (last) state <= D2;
        D2: if (last) state <= D3;
        D3: begin
          if (last) begin
            state <= D1;
            sh1   <= bus.display1;
            sh2   <= bus.display2;
            sh3   <= bus.display3;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_guard = (32'(count) < GUARD);
  assign blank3   = BLANK_ZEROS && (sh3 == ZERO);
  assign blank2   = blank3 && (sh2 == ZERO);

  // Output decode from registered state, counter and shadows only.
  always_comb begin
    seg_d         = '0;
    an_d          = '0;
    frame_start_d = (state == D1) && (count == '0);
    if (!in_guard) begin
      case (state)
        D1: begin
          an_d  = digit_onehot(D1);
          seg_d = sh1;
        end
        D2: begin
          if (!blank2) begin
            an_d  = digit_onehot(D2);
            seg_d = sh2;
          end
        end
        D3: begin
          if (!blank3) begin
            an_d  = digit_onehot(D3);
            seg_d = sh3;
          end
        end
        default: begin
          an_d  = '0;
          seg_d = '0;
        end
      endcase
    end
  end

  assign bus.seg         = seg_d;
  assign bus.an          = an_d;
  assign bus.frame_start = frame_start_d;

endmodule

// File: tb/tb_display_mux_3dig.sv
// Scoreboarded bench for display_mux_3dig: stimulus pushes expected per-cycle
// outputs, a negedge monitor pops and compares them.
module tb_display_mux_3dig;
  import display_mux_3dig_pkg::*;

  localparam int TB_DIV   = 4;
  localparam int TB_GUARD = 1;

  logic clk;
  logic rst_a;
  logic rst_b;

  display_mux_3dig_if ifa ();
  display_mux_3dig_if ifb ();

  display_mux_3dig #(
    .REFRESH_DIV(TB_DIV),
    .GUARD      (TB_GUARD),
    .BLANK_ZEROS(1'b1)
  ) dut_a (
    .clock(clk),
    .reset(rst_a),
    .bus  (ifa)
  );

  display_mux_3dig #(
    .REFRESH_DIV(TB_DIV),
    .GUARD      (TB_GUARD),
    .BLANK_ZEROS(1'b0)
  ) dut_b (
    .clock(clk),
    .reset(rst_b),
    .bus  (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         sel;
    logic [2:0] an;
    logic [6:0] seg;
    logic       fs;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] got_an;
  logic [6:0] got_seg;
  logic       got_fs;

  // Monitor: compares every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e       = q.pop_front();
      got_an  = e.sel ? ifb.an          : ifa.an;
      got_seg = e.sel ? ifb.seg         : ifa.seg;
      got_fs  = e.sel ? ifb.frame_start : ifa.frame_start;
      checks++;
      if (got_an !== e.an || got_seg !== e.seg || got_fs !== e.fs) begin
        errors++;
        $display("FAIL %s: got an=%b seg=%b fs=%b, expected an=%b seg=%b fs=%b",
                 e.name, got_an, got_seg, got_fs, e.an, e.seg, e.fs);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit sel, input logic [2:0] an, input logic [6:0] seg,
                     input logic fs, input string nm);
    exp_t x;
    x.sel = sel; x.an = an; x.seg = seg; x.fs = fs; x.name = nm;
    q.push_back(x);
    tick();
  endtask

  task automatic set_in(input bit sel, input logic [6:0] d1, input logic [6:0] d2,
                        input logic [6:0] d3);
    if (sel) begin
      ifb.display1 = d1; ifb.display2 = d2; ifb.display3 = d3;
    end else begin
      ifa.display1 = d1; ifa.display2 = d2; ifa.display3 = d3;
    end
  endtask

  // One frame of expectations; e1..e3 are the hand-derived patterns shown in
  // each slot (APAGADO = slot dark). Optionally changes inputs before cycle
  // chg_at and stops before cycle stop_at.
  task automatic exp_frame(input bit sel, input string nm,
                           input logic [6:0] e1, input logic [6:0] e2, input logic [6:0] e3,
                           input int stop_at, input int chg_at,
                           input logic [6:0] n1, input logic [6:0] n2, input logic [6:0] n3);
    for (int i = 0; i < stop_at; i++) begin
      int slot;
      int c;
      logic [6:0] ev;
      logic lit;
      slot = i / TB_DIV;
      c    = i % TB_DIV;
      ev   = (slot == 0) ? e1 : (slot == 1) ? e2 : e3;
      lit  = (c >= TB_GUARD) && (ev != APAGADO);
      if (i == chg_at) set_in(sel, n1, n2, n3);
      cyc(sel, lit ? 3'(1 << slot) : 3'b000, lit ? ev : APAGADO, (i == 0),
          $sformatf("%s[%0d]", nm, i));
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.enable = 1'b0;
    ifb.enable = 1'b0;
    set_in(0, APAGADO, APAGADO, APAGADO);
    set_in(1, APAGADO, APAGADO, APAGADO);
    tick();

    // Reset state, then idle with enable low.
    cyc(0, 3'b000, APAGADO, 1'b0, "a_reset");
    rst_a = 1'b0;
    set_in(0, SETE, ZERO, ZERO);
    cyc(0, 3'b000, APAGADO, 1'b0, "a_idle");
    ifa.enable = 1'b1;
    cyc(0, 3'b000, APAGADO, 1'b0, "a_idle_en");

    // Value 7: only units lit, frame repeats every 12 cycles.
    exp_frame(0, "v7_f1", SETE, APAGADO, APAGADO, 12, -1, '0, '0, '0);
    exp_frame(0, "v7_f2", SETE, APAGADO, APAGADO, 12, 11, SETE, DOIS, UM);
    // Value 127: all three digits.
    exp_frame(0, "v127", SETE, DOIS, UM, 12, 11, CINCO, ZERO, UM);
    // Value 105: inner zero shown because hundreds is not blank.
    exp_frame(0, "v105", CINCO, ZERO, UM, 12, 11, SETE, DOIS, UM);
    // Change to 45 during D2: rest of frame still 127.
    exp_frame(0, "v127_chg", SETE, DOIS, UM, 12, 6, CINCO, QUATRO, ZERO);
    exp_frame(0, "v45", CINCO, QUATRO, APAGADO, 12, -1, '0, '0, '0);

    // Reset mid D2.
    exp_frame(0, "pre_rst", CINCO, QUATRO, APAGADO, 6, -1, '0, '0, '0);
    rst_a = 1'b1;
    cyc(0, 3'b010, QUATRO, 1'b0, "pre_rst[6]");
    rst_a = 1'b0;
    cyc(0, 3'b000, APAGADO, 1'b0, "post_rst");
    exp_frame(0, "resume_rst", CINCO, QUATRO, APAGADO, 12, -1, '0, '0, '0);

    // enable=0 mid D2; shadows kept, inputs reloaded on re-entry.
    exp_frame(0, "pre_dis", CINCO, QUATRO, APAGADO, 5, -1, '0, '0, '0);
    ifa.enable = 1'b0;
    cyc(0, 3'b010, QUATRO, 1'b0, "pre_dis[5]");
    set_in(0, SETE, DOIS, UM);
    cyc(0, 3'b000, APAGADO, 1'b0, "dis_idle0");
    ifa.enable = 1'b1;
    cyc(0, 3'b000, APAGADO, 1'b0, "dis_idle1");
    exp_frame(0, "reen", SETE, DOIS, UM, 12, -1, '0, '0, '0);

    // No blanking: value 0 lights all three digits, then value 7.
    rst_b = 1'b0;
    cyc(1, 3'b000, APAGADO, 1'b0, "b_reset");
    set_in(1, ZERO, ZERO, ZERO);
    ifb.enable = 1'b1;
    cyc(1, 3'b000, APAGADO, 1'b0, "b_idle");
    exp_frame(1, "b_v0", ZERO, ZERO, ZERO, 12, 11, SETE, ZERO, ZERO);
    exp_frame(1, "b_v7", SETE, ZERO, ZERO, 12, -1, '0, '0, '0);

    tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_mux_3dig.md
Name: display_mux_3dig

Overview:
- Downstream stage of the binary-to-three-digit 7-segment decoder.
- Takes the three decoded digit patterns (units, tens, hundreds) and time-multiplexes them onto one shared segment bus, with one-hot digit enables.
- Adds frame-atomic input capture, leading-zero blanking and an anti-ghosting guard interval.
- Its outputs drive the board display pins directly.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot; legal range is 2 or more.
- GUARD, 2: cycles at the start of each slot with all digits disabled; legal range is 0 to REFRESH_DIV-1.
- BLANK_ZEROS, 1: 1 enables leading-zero blanking; 0 always shows all three digits.

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 means scan; 0 means display dark
- display1  in  7  units pattern, bit6..0 = a..g, active-high
- display2  in  7  tens pattern, same encoding
- display3  in  7  hundreds pattern, same encoding
- seg  out  7  shared segment bus, bit6..0 = a..g, active-high
- an  out  3  digit enables, active-high one-hot: an[0]=units, an[1]=tens, an[2]=hundreds
- frame_start  out  1  high for exactly the first cycle of each frame

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, slot counter=0, shadow registers sh1/sh2/sh3=0000000.
  - Outputs seg=0, an=000, frame_start=0 from the cycle after the reset edge.
  - Reset has priority over enable and takes effect the same way mid-scan.
- Output timing: seg, an and frame_start are combinational decodes of registered state, counter and shadows only. There is no path from display1..3 or enable to the outputs.
- States are IDLE, D1, D2, D3.
- IDLE:
  - Outputs are all zero.
  - enable=1 at an edge: go to D1, counter=0, load sh1..3 from display1..3.
- Dn (counter 0..REFRESH_DIV-1):
  - At counter=REFRESH_DIV-1: D1 goes to D2, D2 goes to D3, D3 goes to D1. Counter returns to 0.
  - On the D3 to D1 transition, sh1..3 are reloaded from the inputs. This is the only load point besides the IDLE to D1 entry.
- enable=0 at any edge: go to IDLE, counter=0. Shadows are kept.
- frame_start = (state==D1 && counter==0).
- Guard interval: while counter < GUARD, an=000 and seg=0000000.
- After the guard interval, with digit n not blanked: an is one-hot for n and seg=shn.
- Blanking (BLANK_ZEROS=1):
  - Hundreds is blanked if sh3==ZERO.
  - Tens is blanked if hundreds is blanked and sh2==ZERO.
  - Units is never blanked.
  - A blanked slot keeps its full duration with an=000 and seg=0. The scan is not shortened.
- Patterns that are not digits are passed through unchanged and are never treated as ZERO.
- Input changes mid-frame are invisible until the next frame load.
- Counter width is clog2(REFRESH_DIV); it never exceeds REFRESH_DIV-1.

Decomposition:
- Shared package:
  - Segment constants ZERO=1111110, UM=0110000, DOIS=1101101, TRES=1111001, QUATRO=0110011, CINCO=1011011, SEIS=0011111, SETE=1110000, OITO=1111111, NOVE=1110011, APAGADO=0000000.
  - State encoding IDLE/D1/D2/D3.
- Sub-module scan_tick: parameterised counter that produces the slot counter value and a last-cycle strike, with sync clear. The FSM, shadows and blanking stay in the top module.

Test Plan (REFRESH_DIV=4, GUARD=1, BLANK_ZEROS=1 unless stated):
- Value 7 (display1=SETE, display2=display3=ZERO), enable rises → over 12 cycles from frame_start:
  - an = 000,001,001,001, then 000 for 8 cycles.
  - seg = 1110000 only while an=001.
  - frame_start repeats every 12 cycles.
- Value 127 (UM, DOIS, SETE) → an cycles 001, 010, 100, each 3 cycles after 1 guard cycle. seg = SETE, DOIS, UM respectively.
- Value 105 (CINCO, ZERO, UM) → tens is not blanked: an=010 with seg=1111110 during the D2 slot.
- BLANK_ZEROS=0, value 0 → all three slots lit with seg=1111110.
- Change inputs from 127 to 45 during D2 → rest of the frame still shows 127 patterns. The next frame shows QUATRO/CINCO, with hundreds blanked.
- Reset, or enable=0, asserted mid D2 → next cycle an=000, seg=0, frame_start=0; state returns to IDLE.
- On re-enable, the first frame starts with frame_start=1 and an=000 (guard).
